udt_hs_parse: RTL and testbench
===============================

UDT_HS_PARSE -- requirements
Module: udt_hs_parse

Interface
REQ-001 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have ports handshake_tdata (input, 64 bits), handshake_tkeep (input, 8 bits), handshake_tvalid (input, 1 bit) and handshake_tlast (input, 1 bit): the AXI-stream carrying received UDT control packets.
REQ-004 SHALL have port handshake_tready, output, 1 bit: the AXI-stream ready.
REQ-005 SHALL have ports hs_valid (output, 1 bit) and hs_ready (input, 1 bit): the parsed-handshake handshake toward the listen stage.
REQ-006 SHALL have 32-bit outputs hs_version, hs_sock_type, hs_isn, hs_mss, hs_flight, hs_req_type, hs_sock_id and hs_cookie, plus hs_peer_ip (output, 128 bits): the decoded handshake fields.
REQ-007 SHALL have port drop_cnt, output, 16 bits: count of discarded packets.
REQ-008 SHALL have port expect_cookie, input, 32 bits, present only when UDT_HS_COOKIE_CHK_EN is defined.

Function
REQ-009 SHALL accept packets of exactly 8 beats (64 bytes), with word order big-endian: bits [63:32] of a beat are the earlier word.
REQ-010 SHALL map the beats as follows: beat0 = {hdr0, hdr1}; beat1 = {timestamp, dst_sock}; beat2 = {version, sock_type}; beat3 = {isn, mss}; beat4 = {flight, req_type}; beat5 = {sock_id, cookie}; beats 6-7 = peer_ip (beat6 is the upper 64 bits).
REQ-011 SHALL treat a packet as valid only if hdr0[31] = 1 (control packet) and hdr0[30:16] = 0 (handshake type).
REQ-012 SHALL implement the FSM states RECV, HOLD and DROP, with a 3-bit beat counter that is cleared on entry to RECV.
REQ-013 In RECV, SHALL drive handshake_tready = 1 and capture the beat's fields on each tvalid&tready transfer.
REQ-014 SHALL go RECV -> HOLD when beat 7 transfers with tlast = 1, no error is latched and the header check passes; fields update in that cycle and hs_valid = 1 from the next cycle.
REQ-015 In HOLD, SHALL drive handshake_tready = 0 and hold hs_valid and all fields stable until hs_valid & hs_ready; it then returns to RECV in the next cycle.
REQ-016 SHALL set a sticky error if any beat has tkeep != 8'hFF; on the final beat the packet is dropped.
REQ-017 On tlast before beat 7, SHALL drop the packet, stay in RECV and clear the counter.
REQ-018 On beat 7 without tlast, SHALL drop the packet and enter DROP.
REQ-019 In DROP, SHALL keep tready = 1 and discard beats until a tlast transfer, then return to RECV.
REQ-020 A drop SHALL increment drop_cnt by 1, exactly once per packet, saturating at 16'hFFFF.
REQ-021 A dropped packet SHALL NOT modify the hs_* field outputs and SHALL NOT assert hs_valid.
REQ-022 Output field registers SHALL change only on a transfer that completes a valid packet.
REQ-023 SHALL have zero bubble cycles between packets while in RECV.

Reset
REQ-024 While rst_n = 0, SHALL force handshake_tready = 0, hs_valid = 0, all hs_* fields = 0, drop_cnt = 0, the state to RECV and the beat counter to 0.
REQ-025 handshake_tready SHALL be a register that rises on the first clk edge after rst_n deasserts.
REQ-026 Reset mid-packet SHALL abandon the partial packet without incrementing drop_cnt.

Configuration
REQ-027 With UDT_HS_COOKIE_CHK_EN defined, SHALL add port expect_cookie and SHALL drop a valid-format packet with req_type = 32'hFFFFFFFF (response) whose cookie != expect_cookie, counting it in drop_cnt.
REQ-028 Without UDT_HS_COOKIE_CHK_EN, SHALL have no expect_cookie port and SHALL perform no cookie comparison.

Verification
REQ-029 SHALL verify: 8-beat handshake with hdr0 = 32'h8000_0000, isn = 32'h1234_5678, mss = 32'd8000, hs_ready = 1 -> hs_valid pulses for 1 cycle, hs_isn = 32'h1234_5678, hs_mss = 8000, drop_cnt = 0.
REQ-030 SHALL verify: valid packet with hs_ready held at 0 for 10 cycles -> hs_valid stays 1, fields stable and tready = 0 for those 10 cycles; a second packet is accepted only after hs_ready.
REQ-031 SHALL verify: 5-beat packet (tlast on beat 4) followed by a valid packet -> drop_cnt = 1 and only the second packet is presented.
REQ-032 SHALL verify: 10-beat packet, and a packet with tkeep = 8'h0F on beat 3 -> drop_cnt = 2, hs_valid never asserted, fields unchanged.
REQ-033 SHALL verify: hdr0 = 32'h8002_0000 (non-handshake control packet) -> drop_cnt increments, no hs_valid.
REQ-034 SHALL verify with UDT_HS_COOKIE_CHK_EN: expect_cookie = 32'hCAFE_0001, response packet with cookie = 32'hCAFE_0002 -> dropped; with cookie = 32'hCAFE_0001 -> presented; rst_n pulled low on beat 4 -> tready = 0 and drop_cnt = 0.

Source files
------------

// File: rtl/udt_hs_parse_if.sv
// Bundle for udt_hs_parse: the inbound AXI-stream of UDT control packets and
// the parsed-handshake output (valid/ready plus decoded fields) toward listen.
interface udt_hs_parse_if;
  logic [63:0]  handshake_tdata;
  logic [7:0]   handshake_tkeep;
  logic         handshake_tvalid;
  logic         handshake_tlast;
  logic         handshake_tready;

  logic         hs_valid;
  logic         hs_ready;
  logic [31:0]  hs_version;
  logic [31:0]  hs_sock_type;
  logic [31:0]  hs_isn;
  logic [31:0]  hs_mss;
  logic [31:0]  hs_flight;
  logic [31:0]  hs_req_type;
  logic [31:0]  hs_sock_id;
  logic [31:0]  hs_cookie;
  logic [127:0] hs_peer_ip;

  // Parser side: consumes the stream, produces the handshake record.
  modport slave (
    input  handshake_tdata, handshake_tkeep, handshake_tvalid, handshake_tlast, hs_ready,
    output handshake_tready, hs_valid, hs_version, hs_sock_type, hs_isn, hs_mss,
           hs_flight, hs_req_type, hs_sock_id, hs_cookie, hs_peer_ip
  );

  // Environment side: produces the stream, consumes the handshake record.
  modport master (
    output handshake_tdata, handshake_tkeep, handshake_tvalid, handshake_tlast, hs_ready,
    input  handshake_tready, hs_valid, hs_version, hs_sock_type, hs_isn, hs_mss,
           hs_flight, hs_req_type, hs_sock_id, hs_cookie, hs_peer_ip
  );
endinterface

// File: rtl/udt_hs_parse.sv
// udt_hs_parse: parses 8-beat (64-byte) UDT handshake control packets from a 64-bit stream.
// Define UDT_HS_COOKIE_CHK_EN to add expect_cookie and drop response handshakes with a wrong cookie.
module udt_hs_parse (
  input  logic                 clk,
  input  logic                 rst_n,
  udt_hs_parse_if.slave        hs_bus,
`ifdef UDT_HS_COOKIE_CHK_EN
  input  logic [31:0]          expect_cookie,
`endif
  output logic [15:0]          drop_cnt
);

  typedef enum logic [1:0] {
    RECV = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [2:0] LAST_BEAT = 3'd7;

  state_t       state_reg, state_next;
  logic [2:0]   beat_reg, beat_next;
  logic         err_reg, err_next;
  logic         tready_reg;
  logic         hs_valid_reg;
  logic [15:0]  hdr_type_reg;
  logic [63:0]  ip_hi_reg;
  logic [127:0] peer_ip_reg;
  logic [15:0]  drop_cnt_reg;

  logic         xfer;
  logic         capture;
  logic         keep_bad;
  logic         hdr_ok;
  logic         cookie_bad;
  logic         pkt_ok;
  logic         drop_evt;
  logic         accept;
  logic [31:0]  field_out [8];

  assign xfer     = hs_bus.handshake_tvalid & tready_reg;
  assign capture  = xfer & (state_reg == RECV);
  assign keep_bad = (hs_bus.handshake_tkeep != 8'hFF);
  // hdr0[31] set (control) and hdr0[30:16] clear (handshake type)
  assign hdr_ok   = (hdr_type_reg == 16'h8000);

`ifdef UDT_HS_COOKIE_CHK_EN
  assign cookie_bad = (g_field[5].sh_reg == 32'hFFFF_FFFF) && (g_field[7].sh_reg != expect_cookie);
`else
  assign cookie_bad = 1'b0;
`endif

  assign pkt_ok = !err_reg && !keep_bad && hdr_ok && !cookie_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RECV;
      beat_reg  <= 3'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    err_next   = err_reg;
    drop_evt   = 1'b0;
    accept     = 1'b0;
    unique case (state_reg)
      RECV: begin
        if (xfer) begin
          if (beat_reg == LAST_BEAT) begin
            beat_next = 3'd0;
            err_next  = 1'b0;
            if (!hs_bus.handshake_tlast) begin
              drop_evt   = 1'b1;
              state_next = DROP;
            end else if (pkt_ok) begin
              accept     = 1'b1;
              state_next = HOLD;
            end else begin
              drop_evt = 1'b1;
            end
          end else if (hs_bus.handshake_tlast) begin
            beat_next = 3'd0;
            err_next  = 1'b0;
            drop_evt  = 1'b1;
          end else begin
            beat_next = beat_reg + 3'd1;
            err_next  = err_reg | keep_bad;
          end
        end
      end
      HOLD: begin
        if (hs_bus.hs_ready) begin
          state_next = RECV;
          beat_next  = 3'd0;
          err_next   = 1'b0;
        end
      end
      DROP: begin
        // already counted when the overlong packet hit beat 7
        if (xfer && hs_bus.handshake_tlast) begin
          state_next = RECV;
          beat_next  = 3'd0;
          err_next   = 1'b0;
        end
      end
      default: begin
        state_next = RECV;
        beat_next  = 3'd0;
        err_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tready_reg   <= 1'b0;
      hs_valid_reg <= 1'b0;
      hdr_type_reg <= 16'd0;
      ip_hi_reg    <= 64'd0;
      peer_ip_reg  <= 128'd0;
      drop_cnt_reg <= 16'd0;
    end else begin
      tready_reg   <= (state_next != HOLD);
      hs_valid_reg <= (state_next == HOLD);
      if (capture && beat_reg == 3'd0) begin
        hdr_type_reg <= hs_bus.handshake_tdata[63:48];
      end
      if (capture && beat_reg == 3'd6) begin
        ip_hi_reg <= hs_bus.handshake_tdata;
      end
      if (accept) begin
        peer_ip_reg <= {ip_hi_reg, hs_bus.handshake_tdata};
      end
      if (drop_evt && drop_cnt_reg != 16'hFFFF) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  // Field gi lives in beat gi/2+2; even indices are the upper (earlier) word.
  // sh_reg shadows the packet in flight, out_reg only moves on an accepted packet.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_field
      localparam logic [2:0] SRC_BEAT = 3'(gi / 2 + 2);
      localparam int         LSB      = (gi % 2 == 0) ? 32 : 0;
      logic [31:0] sh_reg;
      logic [31:0] out_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_reg  <= 32'd0;
          out_reg <= 32'd0;
        end else begin
          if (capture && beat_reg == SRC_BEAT) begin
            sh_reg <= hs_bus.handshake_tdata[LSB +: 32];
          end
          if (accept) begin
            out_reg <= sh_reg;
          end
        end
      end

      assign field_out[gi] = out_reg;
    end
  endgenerate

  assign hs_bus.handshake_tready = tready_reg;
  assign hs_bus.hs_valid         = hs_valid_reg;
  assign hs_bus.hs_version       = field_out[0];
  assign hs_bus.hs_sock_type     = field_out[1];
  assign hs_bus.hs_isn           = field_out[2];
  assign hs_bus.hs_mss           = field_out[3];
  assign hs_bus.hs_flight        = field_out[4];
  assign hs_bus.hs_req_type      = field_out[5];
  assign hs_bus.hs_sock_id       = field_out[6];
  assign hs_bus.hs_cookie        = field_out[7];
  assign hs_bus.hs_peer_ip       = peer_ip_reg;
  assign drop_cnt                = drop_cnt_reg;

endmodule

// File: tb/tb_udt_hs_parse.sv
// Scoreboard bench for udt_hs_parse: random and directed packets, expectations
// derived from the packet-acceptance rules, checked by an independent monitor.
module tb_udt_hs_parse;
  localparam logic [31:0] EXP_COOKIE = 32'hCAFE_0001;

  typedef struct packed {
    logic [31:0]  version;
    logic [31:0]  sock_type;
    logic [31:0]  isn;
    logic [31:0]  mss;
    logic [31:0]  flight;
    logic [31:0]  req_type;
    logic [31:0]  sock_id;
    logic [31:0]  cookie;
    logic [127:0] peer_ip;
  } hs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] drop_cnt;

  udt_hs_parse_if bus();

  always #5 clk = ~clk;

  udt_hs_parse dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hs_bus       (bus),
`ifdef UDT_HS_COOKIE_CHK_EN
    .expect_cookie(EXP_COOKIE),
`endif
    .drop_cnt     (drop_cnt)
  );

  hs_t         cur;
  hs_t         last_shown;
  hs_t         prev_f;
  hs_t         now_f;
  hs_t         exp_v;
  logic [31:0] cur_hdr0;
  logic [63:0] pd [16];
  logic [7:0]  pk [16];
  int          plen;
  hs_t         exp_q [$];
  int          checks = 0;
  int          passes = 0;
  int          exp_drops = 0;
  int          shown = 0;
  int          hold_cycles = 0;
  int          ready_mode = 2;   // 0 random, 1 hold low, 2 hold high
  bit          prev_valid = 1'b0;
  bit          prev_ack = 1'b0;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  function automatic hs_t dut_fields();
    return {bus.hs_version, bus.hs_sock_type, bus.hs_isn, bus.hs_mss, bus.hs_flight,
            bus.hs_req_type, bus.hs_sock_id, bus.hs_cookie, bus.hs_peer_ip};
  endfunction

  task automatic random_fields();
    cur.version   = $urandom;
    cur.sock_type = $urandom;
    cur.isn       = $urandom;
    cur.mss       = $urandom;
    cur.flight    = $urandom;
    cur.req_type  = $urandom;
    cur.sock_id   = $urandom;
    cur.cookie    = $urandom;
    cur.peer_ip   = {$urandom, $urandom, $urandom, $urandom};
    cur_hdr0      = {16'h8000, 16'($urandom)};
  endtask

  task automatic make_beats();
    pd[0] = {cur_hdr0, 32'($urandom)};
    pd[1] = {32'($urandom), 32'($urandom)};
    pd[2] = {cur.version, cur.sock_type};
    pd[3] = {cur.isn, cur.mss};
    pd[4] = {cur.flight, cur.req_type};
    pd[5] = {cur.sock_id, cur.cookie};
    pd[6] = cur.peer_ip[127:64];
    pd[7] = cur.peer_ip[63:0];
    for (int i = 8; i < 16; i++) pd[i] = {32'($urandom), 32'($urandom)};
    for (int i = 0; i < 16; i++) pk[i] = 8'hFF;
    plen = 8;
  endtask

  // kind: 0 valid, 1 short, 2 long, 3 bad tkeep, 4 bad header, 5 response w/ cookie
  task automatic gen(input int kind);
    random_fields();
    if (kind == 4) begin
      if ($urandom_range(0, 1) == 0) cur_hdr0 = {1'b0, 31'($urandom)};
      else cur_hdr0 = {1'b1, 15'($urandom_range(1, 32767)), 16'($urandom)};
    end
    if (kind == 5) begin
      cur.req_type = 32'hFFFF_FFFF;
      cur.cookie   = ($urandom_range(0, 1) == 0) ? EXP_COOKIE : EXP_COOKIE + 32'd1;
    end
    make_beats();
    if (kind == 1) plen = $urandom_range(1, 7);
    if (kind == 2) plen = $urandom_range(9, 12);
    if (kind == 3) pk[$urandom_range(0, 7)] = 8'($urandom_range(0, 254));
  endtask

  // A packet is presented iff it is exactly 8 full beats of handshake-type control.
  function automatic bit model_ok();
    bit ok;
    ok = (plen == 8) && cur_hdr0[31] && (cur_hdr0[30:16] == 15'd0);
    for (int i = 0; i < 8; i++) if (pk[i] != 8'hFF) ok = 1'b0;
`ifdef UDT_HS_COOKIE_CHK_EN
    if (cur.req_type == 32'hFFFF_FFFF && cur.cookie != EXP_COOKIE) ok = 1'b0;
`endif
    return ok;
  endfunction

  task automatic abort_run(input string why);
    $display("FAIL %s: got timeout required progress", why);
    checks++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (bus.handshake_tready !== 1'b1) begin
      @(negedge clk);
      t++;
      if (t > 1000) abort_run("tready_timeout");
    end
  endtask

  task automatic send_beats(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 4) == 0) @(negedge clk);
      @(negedge clk);
      bus.handshake_tdata  = pd[i];
      bus.handshake_tkeep  = pk[i];
      bus.handshake_tlast  = (i == plen - 1);
      bus.handshake_tvalid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1 bus.handshake_tvalid = 1'b0;
    end
  endtask

  task automatic send_pkt(input bit gaps);
    if (model_ok()) exp_q.push_back(cur);
    else exp_drops++;
    send_beats(plen, gaps);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_queue_empty"}, 384'(exp_q.size()), 384'(0));
    repeat (4) @(negedge clk);
    chk({tag, "_drop_cnt"}, 384'(drop_cnt), 384'(exp_drops[15:0]));
    chk({tag, "_fields_hold"}, dut_fields(), last_shown);
  endtask

  // Monitor: drives hs_ready and checks whatever the DUT presents.
  always @(negedge clk) begin
    if (ready_mode == 0) bus.hs_ready = ($urandom_range(0, 3) != 0);
    else bus.hs_ready = (ready_mode == 2);
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      now_f = dut_fields();
      if (prev_ack) chk("hs_valid_single_pulse", 384'(bus.hs_valid), 384'(0));
      if (bus.hs_valid) begin
        chk("tready_low_in_hold", 384'(bus.handshake_tready), 384'(0));
        if (prev_valid && !prev_ack) chk("fields_stable_in_hold", now_f, prev_f);
        if (!bus.hs_ready) hold_cycles++;
        else if (exp_q.size() == 0) chk("unexpected_hs_valid", 384'(bus.hs_valid), 384'(0));
        else begin
          exp_v = exp_q.pop_front();
          chk("hs_fields", now_f, exp_v);
          last_shown = exp_v;
          shown++;
        end
      end
      prev_valid = bus.hs_valid;
      prev_ack   = bus.hs_valid && bus.hs_ready;
      prev_f     = now_f;
    end
  end

  initial begin
    int h0;
    int s0;
    bus.handshake_tdata  = 64'd0;
    bus.handshake_tkeep  = 8'd0;
    bus.handshake_tvalid = 1'b0;
    bus.handshake_tlast  = 1'b0;
    bus.hs_ready         = 1'b0;
    last_shown           = '0;

    repeat (3) @(negedge clk);
    chk("reset_tready", 384'(bus.handshake_tready), 384'(0));
    chk("reset_hs_valid", 384'(bus.hs_valid), 384'(0));
    chk("reset_drop_cnt", 384'(drop_cnt), 384'(0));
    chk("reset_fields", dut_fields(), 384'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_reset", 384'(bus.handshake_tready), 384'(1));

    // Basic handshake with ready held high
    s0 = shown;
    random_fields();
    cur_hdr0 = 32'h8000_0000;
    cur.isn  = 32'h1234_5678;
    cur.mss  = 32'd8000;
    make_beats();
    send_pkt(1'b0);
    drain("basic");
    chk("basic_presented", 384'(shown - s0), 384'(1));

    // Consumer stalls: hold must persist, next packet waits for hs_ready
    ready_mode = 1;
    gen(0);
    send_pkt(1'b0);
    h0 = hold_cycles;
    fork
      begin
        repeat (12) @(negedge clk);
        ready_mode = 2;
      end
    join_none
    gen(0);
    send_pkt(1'b0);
    drain("stall");
    chk("stall_hold_ge_10", 384'((hold_cycles - h0) >= 10), 384'(1));

    // Short packet then valid; long packet; bad tkeep on beat 3; bad header
    gen(0); plen = 5; send_pkt(1'b0);
    gen(0); send_pkt(1'b0);
    drain("short");
    s0 = shown;
    gen(0); plen = 10; send_pkt(1'b0);
    gen(0); pk[3] = 8'h0F; send_pkt(1'b0);
    random_fields(); cur_hdr0 = 32'h8002_0000; make_beats(); send_pkt(1'b0);
    drain("bad");
    chk("bad_none_presented", 384'(shown - s0), 384'(0));

`ifdef UDT_HS_COOKIE_CHK_EN
    s0 = shown;
    gen(0); cur.req_type = 32'hFFFF_FFFF; cur.cookie = 32'hCAFE_0002; make_beats(); send_pkt(1'b0);
    gen(0); cur.req_type = 32'hFFFF_FFFF; cur.cookie = 32'hCAFE_0001; make_beats(); send_pkt(1'b0);
    drain("cookie");
    chk("cookie_presented", 384'(shown - s0), 384'(1));
`endif

    // Randomized mix with back-pressure and input gaps
    ready_mode = 0;
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) gen(0);
      else if (r == 9) gen(5);
      else gen(r - 4);
      send_pkt($urandom_range(0, 1) == 1);
    end
    drain("random");

    // Reset in the middle of a packet
    ready_mode = 2;
    gen(0);
    send_beats(4, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tready", 384'(bus.handshake_tready), 384'(0));
    chk("midrst_drop_cnt", 384'(drop_cnt), 384'(0));
    chk("midrst_hs_valid", 384'(bus.hs_valid), 384'(0));
    chk("midrst_fields", dut_fields(), 384'(0));
    exp_drops  = 0;
    last_shown = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_tready_rise", 384'(bus.handshake_tready), 384'(1));
    gen(0);
    send_pkt(1'b0);
    drain("post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
